// File: rtl/pdm_receiver_if.sv
// Signal bundle between the PDM receiver and its surroundings: microphone
// pins, run control and the decimated sample stream.
interface pdm_receiver_if #(
  parameter int OUT_W = 9
);
  logic                    enable_in;
  logic                    mic_data_in;
  logic                    mic_clk_out;
  logic                    tick_out;
  logic signed [OUT_W-1:0] sample_out;
  logic                    sample_valid_out;

  modport slave (
    input  enable_in, mic_data_in,
    output mic_clk_out, tick_out, sample_out, sample_valid_out
  );

  modport master (
    output enable_in, mic_data_in,
    input  mic_clk_out, tick_out, sample_out, sample_valid_out
  );
endinterface

// File: rtl/pdm_receiver.sv
// PDM microphone receiver: generates mic_clk_out, captures one PDM bit per
// clock period and emits a centred ones-count every DECIM bits.
module pdm_receiver #(
  parameter int CLK_DIV = 32,
  parameter int DECIM   = 256
) (
  input logic           clk_in,
  input logic           rst_in,
  pdm_receiver_if.slave bus
);
  localparam int HALF  = CLK_DIV / 2;
  localparam int OUT_W = $clog2(DECIM) + 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DECIM);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_C   = DIV_W'(HALF);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DECIM - 1);

  // Ones-count spans 0..DECIM; subtracting DECIM/2 always fits in OUT_W signed bits.
  function automatic logic signed [OUT_W-1:0] center_sample(input logic [OUT_W-1:0] ones);
    logic signed [OUT_W:0] wide;
    wide = $signed({1'b0, ones}) - $signed((OUT_W + 1)'(DECIM / 2));
    return $signed(wide[OUT_W-1:0]);
  endfunction

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic                    mic_clk_q, mic_clk_d;
  logic                    tick_q, tick_d;
  logic [OUT_W-1:0]        tally_q, tally_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic signed [OUT_W-1:0] sample_q, sample_d;
  logic                    valid_q, valid_d;

  logic             capture;
  logic [OUT_W-1:0] ones;

  // Capture on the last low cycle of mic_clk, just before its rising edge.
  assign capture = bus.enable_in && (div_cnt_q == DIV_LAST);
  assign ones    = tally_q + OUT_W'(bus.mic_data_in);

  always_comb begin
    div_cnt_d = '0;
    mic_clk_d = 1'b0;
    tick_d    = capture;
    tally_d   = '0;
    bit_cnt_d = '0;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    if (bus.enable_in) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
      mic_clk_d = (div_cnt_d < HALF_C);
      tally_d   = tally_q;
      bit_cnt_d = bit_cnt_q;
      if (capture) begin
        if (bit_cnt_q == BIT_LAST) begin
          sample_d  = center_sample(ones);
          valid_d   = 1'b1;
          tally_d   = '0;
          bit_cnt_d = '0;
        end else begin
          tally_d   = ones;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt_q <= '0;
      mic_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      tally_q   <= '0;
      bit_cnt_q <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      mic_clk_q <= mic_clk_d;
      tick_q    <= tick_d;
      tally_q   <= tally_d;
      bit_cnt_q <= bit_cnt_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.mic_clk_out      = mic_clk_q;
  assign bus.tick_out         = tick_q;
  assign bus.sample_out       = sample_q;
  assign bus.sample_valid_out = valid_q;
endmodule

// File: tb/tb_pdm_receiver.sv
// Scoreboard bench for pdm_receiver: default build plus a CLK_DIV=4/DECIM=2 build.
module tb_pdm_receiver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pdm_receiver_if #(.OUT_W(9)) bb();
  pdm_receiver_if #(.OUT_W(2)) sb();

  pdm_receiver #(.CLK_DIV(32), .DECIM(256)) dut_big (
    .clk_in(clk), .rst_in(rst), .bus(bb)
  );
  pdm_receiver #(.CLK_DIV(4), .DECIM(2)) dut_small (
    .clk_in(clk), .rst_in(rst), .bus(sb)
  );

  typedef struct {
    int     val;
    longint cyc;
  } exp_t;

  exp_t   qb[$];
  exp_t   qs[$];
  int     checks = 0;
  int     fails  = 0;
  longint cyc    = 0;
  longint en_cyc = 0;
  int     mode   = 0;
  int     idx    = 0;
  int     sidx   = 0;
  bit     chk_clk = 1'b0;
  logic   spat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the head of its queue in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bb.sample_valid_out === 1'b1) begin
      if (qb.size() == 0) check("unexpected_valid_big", bb.sample_valid_out, 0);
      else begin
        e = qb.pop_front();
        check("sample_big", $signed(bb.sample_out), e.val);
        check("valid_cycle_big", cyc, e.cyc);
      end
    end
    if (sb.sample_valid_out === 1'b1) begin
      if (qs.size() == 0) check("unexpected_valid_small", sb.sample_valid_out, 0);
      else begin
        e = qs.pop_front();
        check("sample_small", $signed(sb.sample_out), e.val);
        check("valid_cycle_small", cyc, e.cyc);
      end
    end
  end

  function automatic logic big_bit(input int m, input int k);
    if (m == 0) return 1'b0;
    if (m == 1) return 1'b1;
    return (k % 2 == 0);
  endfunction

  task automatic step();
    longint n;
    @(negedge clk);
    if (bb.tick_out) idx++;
    bb.mic_data_in = big_bit(mode, idx);
    if (sb.tick_out) sidx++;
    sb.mic_data_in = spat[sidx % 4];
    if (chk_clk) begin
      n = cyc - en_cyc;
      check("mic_clk_phase", bb.mic_clk_out, ((n % 32) < 16));
      check("tick_phase", bb.tick_out, (n > 0 && (n % 32) == 0));
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((qb.size() > 0 || qs.size() > 0) && k < budget) begin
      step();
      k++;
    end
    if (qb.size() > 0 || qs.size() > 0) check("drain_timeout", qb.size() + qs.size(), 0);
  endtask

  task automatic start_big(input int m);
    mode = m;
    idx  = 0;
    bb.mic_data_in = big_bit(m, 0);
    bb.enable_in   = 1'b1;
    en_cyc = cyc;
  endtask

  task automatic stop_check(input string tag);
    bb.enable_in = 1'b0;
    run(3);
    check({tag, "_off_mic_clk"}, bb.mic_clk_out, 0);
    check({tag, "_off_tick"}, bb.tick_out, 0);
  endtask

  initial begin
    rst = 1'b1;
    bb.enable_in = 1'b0; bb.mic_data_in = 1'b0;
    sb.enable_in = 1'b0; sb.mic_data_in = 1'b0;
    #1;
    check("rst_mic_clk", bb.mic_clk_out, 0);
    check("rst_tick", bb.tick_out, 0);
    check("rst_sample", $signed(bb.sample_out), 0);
    check("rst_valid", bb.sample_valid_out, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Small build: pattern 1,1,0,1 gives +1 then 0, one sample per 8 cycles.
    sidx = 0;
    sb.mic_data_in = 1'b1;
    sb.enable_in = 1'b1;
    en_cyc = cyc;
    qs.push_back('{val: 1, cyc: en_cyc + 8});
    qs.push_back('{val: 0, cyc: en_cyc + 16});
    drain(40);
    sb.enable_in = 1'b0;
    run(3);
    check("small_off_mic_clk", sb.mic_clk_out, 0);

    // All ones: two +128 samples 8192 cycles apart.
    start_big(1);
    qb.push_back('{val: 128, cyc: en_cyc + 8192});
    qb.push_back('{val: 128, cyc: en_cyc + 16384});
    drain(17000);
    stop_check("ones");
    check("hold_after_disable", $signed(bb.sample_out), 128);

    // All zeros: -128.
    start_big(0);
    qb.push_back('{val: -128, cyc: en_cyc + 8192});
    drain(9000);
    stop_check("zeros");

    // Alternating 1/0: zero, with clock phase and tick placement checked.
    start_big(2);
    qb.push_back('{val: 0, cyc: en_cyc + 8192});
    chk_clk = 1'b1;
    run(100);
    chk_clk = 1'b0;
    drain(9000);
    stop_check("alt");

    // Partial window discarded across a 50-cycle disable gap.
    start_big(1);
    run(100 * 32 + 5);
    bb.enable_in = 1'b0;
    repeat (50) begin
      step();
      check("gap_mic_clk", bb.mic_clk_out, 0);
    end
    start_big(0);
    qb.push_back('{val: -128, cyc: en_cyc + 8192});
    drain(9000);
    run(20);
    stop_check("regap");

    // Asynchronous reset between edges after 200 captures.
    start_big(1);
    run(200 * 32 + 10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_mic_clk", bb.mic_clk_out, 0);
    check("arst_tick", bb.tick_out, 0);
    check("arst_sample", $signed(bb.sample_out), 0);
    check("arst_valid", bb.sample_valid_out, 0);
    run(3);
    rst = 1'b0;
    idx = 0;
    en_cyc = cyc;
    qb.push_back('{val: 128, cyc: en_cyc + 8192});
    drain(9000);
    run(20);
    stop_check("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pdm_receiver.md
PDM_RECEIVER -- requirements
Module: pdm_receiver

Interface
REQ-001 Parameter: CLK_DIV, default 32, clk_in cycles per mic_clk_out period; even and >= 4.
REQ-002 Parameter: DECIM, default 256, PDM bits per output sample; power of two and >= 2.
REQ-003 Derived: HALF = CLK_DIV/2, OUT_W = $clog2(DECIM)+1 (default 9).
REQ-004 clk_in  input  1  system clock; one clock only; all logic on posedge clk_in.
REQ-005 rst_in  input  1  reset; asynchronous, active-high.
REQ-006 enable_in  input  1  run/stop for clock generation and accumulation.
REQ-007 mic_data_in  input  1  PDM bit from microphone, synchronous to mic_clk_out.
REQ-008 mic_clk_out  output  1  generated microphone clock, registered, glitch-free.
REQ-009 tick_out  output  1  one-cycle pulse per captured PDM bit, for sharing with the PDM transmit path.
REQ-010 sample_out  output  OUT_W  signed decimated sample, two's complement.
REQ-011 sample_valid_out  output  1  one-cycle pulse when sample_out is updated.

Function
REQ-012 Divider counter div_cnt SHALL count 0..CLK_DIV-1 and wrap to 0 on every enabled cycle.
REQ-013 On each enabled cycle, mic_clk_out SHALL be loaded with (next div_cnt < HALF), so that mic_clk_out == (div_cnt < HALF) while enabled, with period CLK_DIV and duty HALF/HALF.
REQ-014 Capture point: in the enabled cycle where div_cnt == CLK_DIV-1 (last low cycle of mic_clk_out), mic_data_in SHALL be captured.
REQ-015 tick_out SHALL be high for exactly the one cycle following each capture; at defaults this is once per 32 cycles.
REQ-016 Accumulation: tally (OUT_W bits, unsigned) SHALL add the captured bit, and bit_cnt SHALL count captures 0..DECIM-1.
REQ-017 Window close: on the capture with bit_cnt == DECIM-1, the receiver SHALL:
  - register sample_out = (tally + bit) - DECIM/2, giving range -DECIM/2..+DECIM/2 with no wrap;
  - clear tally and bit_cnt.
REQ-018 sample_valid_out SHALL pulse high for one cycle, in the same cycle sample_out takes its new value (one cycle after the closing capture).
REQ-019 sample_out SHALL hold its value between pulses.
REQ-020 Output rate SHALL be f_clk/(CLK_DIV*DECIM); at defaults, one sample per 8192 cycles.
REQ-021 While enable_in is low:
  - div_cnt, tally and bit_cnt SHALL be held at 0;
  - mic_clk_out, tick_out and sample_valid_out SHALL be 0;
  - sample_out SHALL hold its value.
REQ-022 If enable_in drops mid-window, the partial window SHALL be discarded with no sample_valid_out pulse; re-enable starts a fresh window at div_cnt = 0.
REQ-023 If enable_in drops in the cycle where a sample_valid_out pulse is due, that pulse SHALL still occur.
REQ-024 The first enabled edge after reset or disable SHALL drive mic_clk_out high.

Reset
REQ-025 rst_in high SHALL immediately, without a clock edge, set the following to 0: div_cnt, tally, bit_cnt, mic_clk_out, tick_out, sample_out, sample_valid_out.
REQ-026 Reset mid-window SHALL discard the window and SHALL NOT produce a sample_valid_out pulse.
REQ-027 After rst_in deasserts, operation SHALL resume per REQ-024.

Verification
REQ-028 Defaults, enable_in = 1, mic_data_in held at 1 -> sample_out = +128 (9'h080), with sample_valid_out every 8192 cycles.
REQ-029 mic_data_in held at 0 -> sample_out = -128 (9'h180) on every valid.
REQ-030 mic_data_in alternating 1/0 on successive captures -> sample_out = 0; mic_clk_out measured at 16 high / 16 low; tick_out one cycle after each div_cnt = 31 cycle.
REQ-031 100 captures of 1, then enable_in low for 50 cycles, then re-enable with 256 zeros -> no valid during the gap, then exactly one valid with -128 at 8192 cycles after re-enable.
REQ-032 rst_in asserted asynchronously (between clock edges) after 200 captures -> all outputs 0 before the next clk_in edge; no valid pulse; first valid 8192 cycles after release.
REQ-033 CLK_DIV = 4, DECIM = 2, input pattern 1,1,0,1 -> samples +1 then 0, with valid every 8 cycles.
